// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding,
// reset PC and the NOP word delivered on address errors.
package if_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_WAIT = 2'd2,
        IF_DONE = 2'd3
    } if_state_e;

    localparam logic [31:0] IF_RESET_PC = 32'hbfc0_0000;
    localparam logic [31:0] IF_NOP_INST = 32'h0000_0000;

    function automatic logic is_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// SRAM-like instruction bus between the fetch sequencer (master) and memory (slave).
interface if_fetch_ctrl_if;

    // Handshake: the address phase completes on the clock edge where inst_req and
    // inst_addr_ok are both high; the master keeps inst_req/inst_addr stable until then.
    // inst_data_ok marks a one-cycle read response with inst_rdata for the accepted address.
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );

endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: one bus request at a time, flush-aware response
// discard, and a stall request that lets the PC advance once per delivered word.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC,
    parameter logic [31:0] NOP_INST = IF_NOP_INST
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            pc_i,
    input  logic                   flush_i,
    input  logic                   stall_i,
    if_fetch_ctrl_if.master        bus,
    output logic                   inst_valid_o,
    output logic [31:0]            inst_o,
    output logic [31:0]            pc_o,
    output logic                   exc_adel_o,
    output logic                   stallreq_o,
    output if_state_e              state_o
);

    if_state_e   r_state;
    if_state_e   w_next;
    logic [31:0] r_addr;
    logic        r_drop;
    logic        r_valid;
    logic [31:0] r_inst;
    logic [31:0] r_pc;
    logic        r_adel;
    logic        w_consume;
    logic        w_req;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IF_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_req     = 1'b0;
        w_consume = 1'b0;
        case (r_state)
            IF_IDLE: begin
                if (!flush_i) w_next = is_misaligned(pc_i) ? IF_DONE : IF_REQ;
            end
            IF_REQ: begin
                w_req = 1'b1;
                if (bus.inst_addr_ok) w_next = IF_WAIT;
            end
            IF_WAIT: begin
                if (bus.inst_data_ok) w_next = (r_drop || flush_i) ? IF_IDLE : IF_DONE;
            end
            IF_DONE: begin
                w_consume = !stall_i && !flush_i;
                if (flush_i || !stall_i) w_next = IF_IDLE;
            end
            default: w_next = IF_IDLE;
        endcase
    end

    // r_drop remembers a flush seen while a request was outstanding, so the
    // matching response is swallowed even if it arrives cycles later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr  <= 32'h0;
            r_drop  <= 1'b0;
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
            r_pc    <= RESET_PC;
            r_adel  <= 1'b0;
        end else begin
            case (r_state)
                IF_IDLE: begin
                    if (!flush_i) begin
                        if (is_misaligned(pc_i)) begin
                            r_pc    <= pc_i;
                            r_inst  <= NOP_INST;
                            r_adel  <= 1'b1;
                            r_valid <= 1'b1;
                        end else begin
                            r_addr <= pc_i;
                        end
                    end
                end
                IF_REQ: begin
                    if (flush_i) r_drop <= 1'b1;
                end
                IF_WAIT: begin
                    if (bus.inst_data_ok) begin
                        r_drop <= 1'b0;
                        if (!(r_drop || flush_i)) begin
                            r_inst  <= bus.inst_rdata;
                            r_pc    <= r_addr;
                            r_adel  <= 1'b0;
                            r_valid <= 1'b1;
                        end
                    end else if (flush_i) begin
                        r_drop <= 1'b1;
                    end
                end
                IF_DONE: begin
                    if (flush_i || !stall_i) r_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.inst_req  = w_req;
    assign bus.inst_addr = r_addr;
    assign inst_valid_o  = r_valid;
    assign inst_o        = r_inst;
    assign pc_o          = r_pc;
    assign exc_adel_o    = r_adel;
    assign stallreq_o    = !w_consume;
    assign state_o       = r_state;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a reactive bus slave, a flag-level
// reference model, an expected-delivery queue and literal spot checks.
module tb_if_fetch_ctrl;
  import if_fetch_ctrl_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] pc_i;
  logic        flush_i;
  logic        stall_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        exc_adel_o;
  logic        stallreq_o;
  if_state_e   state_o;

  if_fetch_ctrl_if bus();

  if_fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .flush_i      (flush_i),
    .stall_i      (stall_i),
    .bus          (bus),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .pc_o         (pc_o),
    .exc_adel_o   (exc_adel_o),
    .stallreq_o   (stallreq_o),
    .state_o      (state_o)
  );

  // bus slave: accepts after addr_dly request cycles, answers data_dly cycles later
  int          addr_dly = 0;
  int          data_dly = 0;
  logic [31:0] resp [0:7];

  initial begin
    int req_cnt;
    int data_cnt;
    int resp_idx;
    logic waiting;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = 32'h0;
    req_cnt = 0; data_cnt = 0; resp_idx = 0; waiting = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        req_cnt = 0; data_cnt = 0; waiting = 1'b0;
      end else begin
        if (bus.inst_addr_ok) begin
          waiting = 1'b1; data_cnt = 0; req_cnt = 0;
        end
        if (bus.inst_data_ok) begin
          waiting = 1'b0; resp_idx++;
        end
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        if (bus.inst_req) begin
          if (req_cnt >= addr_dly) bus.inst_addr_ok = 1'b1;
          else req_cnt++;
        end
        if (waiting) begin
          if (data_cnt >= data_dly) begin
            bus.inst_data_ok = 1'b1;
            bus.inst_rdata   = resp[resp_idx];
          end else begin
            data_cnt++;
          end
        end
      end
    end
  end

  // reference model: what is outstanding, killed or held for IF/ID
  logic        m_started = 1'b0;
  logic        m_req, m_out, m_kill, m_valid, m_adel;
  logic [31:0] m_addr, m_inst, m_pc;

  always @(posedge clk) begin
    logic o_req, o_out, o_kill, o_valid;
    if (!rst) begin
      m_req = 1'b0; m_out = 1'b0; m_kill = 1'b0; m_valid = 1'b0; m_adel = 1'b0;
      m_addr = 32'h0; m_inst = 32'h0; m_pc = 32'hbfc00000;
    end else begin
      o_req = m_req; o_out = m_out; o_kill = m_kill; o_valid = m_valid;
      if (!o_req && !o_out && !o_valid && !flush_i) begin
        if (pc_i[1:0] != 2'b00) begin
          m_valid = 1'b1; m_pc = pc_i; m_adel = 1'b1; m_inst = 32'h0;
        end else begin
          m_req = 1'b1; m_addr = pc_i;
        end
      end
      if (o_req) begin
        if (flush_i) m_kill = 1'b1;
        if (bus.inst_addr_ok) begin m_req = 1'b0; m_out = 1'b1; end
      end
      if (o_out) begin
        if (bus.inst_data_ok) begin
          m_out = 1'b0;
          if (o_kill || flush_i) m_kill = 1'b0;
          else begin m_valid = 1'b1; m_inst = bus.inst_rdata; m_pc = m_addr; m_adel = 1'b0; end
        end else if (flush_i) begin
          m_kill = 1'b1;
        end
      end
      if (o_valid && (flush_i || !stall_i)) m_valid = 1'b0;
    end
    m_started = 1'b1;
  end

  // scoreboard and counters
  logic [63:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int req_rises = 0;
  int req_cycles = 0;
  int dead_seen = 0;
  logic prev_req = 1'b0;
  logic [31:0] last_req_addr = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [63:0] e;
    if (!m_started) return;
    chk("req",      32'(bus.inst_req),  32'(m_req));
    chk("addr",     bus.inst_addr,      m_addr);
    chk("valid",    32'(inst_valid_o),  32'(m_valid));
    chk("inst",     inst_o,             m_inst);
    chk("pc",       pc_o,               m_pc);
    chk("adel",     32'(exc_adel_o),    32'(m_adel));
    chk("stallreq", 32'(stallreq_o),    32'(!(m_valid && !stall_i && !flush_i)));
    if (rst && inst_valid_o && !stall_i && !flush_i) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc",   pc_o,   e[63:32]);
        chk("sb_inst", inst_o, e[31:0]);
      end
    end
    if (bus.inst_req && !prev_req) begin
      req_rises++;
      last_req_addr = bus.inst_addr;
    end
    if (bus.inst_req) req_cycles++;
    prev_req = bus.inst_req;
    if (inst_valid_o && inst_o == 32'hdeadbeef) dead_seen++;
  endtask

  // one cycle: compare at negedge, step the PC if the stall controller would
  task automatic tick();
    logic adv;
    @(negedge clk);
    compare_all();
    adv = (stallreq_o === 1'b0);
    @(posedge clk);
    #1;
    if (adv) pc_i = pc_i + 32'd4;
  endtask

  task automatic wait_valid(input string name, input int budget, output int n);
    n = 0;
    while (inst_valid_o !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(inst_valid_o), 32'(1));
  endtask

  initial begin
    int n;
    int base_r;
    int base_c;
    pc_i = 32'hbfc00000; flush_i = 1'b0; stall_i = 1'b0;
    resp[0] = 32'h24080001; resp[1] = 32'h3c1d8000; resp[2] = 32'hdeadbeef;
    resp[3] = 32'h8c020010; resp[4] = 32'h11111111; resp[5] = 32'hac430004;
    resp[6] = 32'h0; resp[7] = 32'h0;

    repeat (3) tick();
    chk("rst_req",      32'(bus.inst_req), 32'(0));
    chk("rst_addr",     bus.inst_addr,     32'h0);
    chk("rst_valid",    32'(inst_valid_o), 32'(0));
    chk("rst_inst",     inst_o,            32'h0);
    chk("rst_pc",       pc_o,              32'hbfc00000);
    chk("rst_adel",     32'(exc_adel_o),   32'(0));
    chk("rst_stallreq", 32'(stallreq_o),   32'(1));
    rst = 1'b1;

    // best-case fetch
    exp_q.push_back({32'hbfc00000, 32'h24080001});
    wait_valid("t1_valid", 20, n);
    chk("t1_latency",  32'(n),        32'(3));
    chk("t1_req_addr", last_req_addr, 32'hbfc00000);
    chk("t1_inst",     inst_o,        32'h24080001);
    chk("t1_pc",       pc_o,          32'hbfc00000);
    chk("t1_stallreq_low", 32'(stallreq_o), 32'(0));
    tick();
    chk("t1_stallreq_high", 32'(stallreq_o), 32'(1));
    chk("t1_valid_clear",   32'(inst_valid_o), 32'(0));

    // slow address acceptance
    addr_dly = 3;
    base_r = req_rises; base_c = req_cycles;
    exp_q.push_back({32'hbfc00004, 32'h3c1d8000});
    wait_valid("t2_valid", 30, n);
    chk("t2_one_req",    32'(req_rises - base_r),  32'(1));
    chk("t2_req_cycles", 32'(req_cycles - base_c), 32'(4));
    chk("t2_pc",         pc_o,   32'hbfc00004);
    chk("t2_inst",       inst_o, 32'h3c1d8000);
    tick();

    // flush while waiting for data
    addr_dly = 0; data_dly = 3;
    exp_q.push_back({32'hbfc00380, 32'h8c020010});
    n = 0;
    while (bus.inst_req !== 1'b1 && n < 20) begin tick(); n++; end
    while (bus.inst_req === 1'b1 && n < 40) begin tick(); n++; end
    chk("t3_in_wait", 32'(state_o), 32'(IF_WAIT));
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    pc_i = 32'hbfc00380;
    base_r = req_rises;
    wait_valid("t3_valid", 40, n);
    chk("t3_pc",       pc_o,          32'hbfc00380);
    chk("t3_inst",     inst_o,        32'h8c020010);
    chk("t3_req_addr", last_req_addr, 32'hbfc00380);
    chk("t3_one_req",  32'(req_rises - base_r), 32'(1));
    tick();

    // flush in the data_ok cycle
    data_dly = 2;
    exp_q.push_back({32'hbfc00400, 32'hac430004});
    n = 0;
    do begin tick(); #2; n++; end while (bus.inst_data_ok !== 1'b1 && n < 30);
    chk("t4_saw_data_ok", 32'(bus.inst_data_ok), 32'(1));
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    pc_i = 32'hbfc00400;
    chk("t4_valid_low", 32'(inst_valid_o), 32'(0));
    chk("t4_idle",      32'(state_o),      32'(IF_IDLE));
    stall_i = 1'b1;
    wait_valid("t4_valid", 30, n);
    chk("t4_pc",   pc_o,   32'hbfc00400);
    chk("t4_inst", inst_o, 32'hac430004);

    // hold in DONE under stall
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_hold_valid", 32'(inst_valid_o), 32'(1));
      chk("t5_hold_inst",  inst_o,            32'hac430004);
      chk("t5_hold_pc",    pc_o,              32'hbfc00400);
      chk("t5_hold_stall", 32'(stallreq_o),   32'(1));
    end
    stall_i = 1'b0;
    #1;
    chk("t5_consume_low", 32'(stallreq_o), 32'(0));
    tick();
    chk("t5_after_valid", 32'(inst_valid_o), 32'(0));

    // misaligned PC
    pc_i = 32'hbfc00002;
    stall_i = 1'b1;
    base_r = req_rises;
    exp_q.push_back({32'hbfc00002, 32'h0});
    tick();
    tick();
    tick();
    chk("t6_valid",  32'(inst_valid_o), 32'(1));
    chk("t6_adel",   32'(exc_adel_o),   32'(1));
    chk("t6_inst",   inst_o,            32'h0);
    chk("t6_pc",     pc_o,              32'hbfc00002);
    chk("t6_no_req", 32'(req_rises - base_r), 32'(0));
    stall_i = 1'b0;
    tick();
    chk("t6_consumed", 32'(inst_valid_o), 32'(0));

    chk("sb_drained",  32'(exp_q.size()), 32'(0));
    chk("killed_data", 32'(dead_seen),    32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
